pipelined_register_file: RTL and testbench



---
 rtl/pipelined_register_file_if.sv | 38 +++
 rtl/pipelined_register_file.sv | 112 +++++++++++
 tb/tb_pipelined_register_file.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pipelined_register_file_if.sv
// Register-file bus: write-back port, decode read/reserve request and
// the registered operands and hazard flags returned to decode.
interface pipelined_register_file_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] write_address;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  write_enable;
    logic                  read_enable;
    logic [ADDR_WIDTH-1:0] read_reg_0;
    logic [ADDR_WIDTH-1:0] read_reg_1;
    logic                  read_use_0;
    logic                  read_use_1;
    logic                  reserve_enable;
    logic [ADDR_WIDTH-1:0] reserve_reg;
    logic [DATA_WIDTH-1:0] read_data_0;
    logic [DATA_WIDTH-1:0] read_data_1;
    logic                  read_valid;
    logic                  stall;
    logic                  scoreboard_error;

    // Decode / write-back side
    modport master (
        output write_address, write_data, write_enable,
        output read_enable, read_reg_0, read_reg_1, read_use_0, read_use_1,
        output reserve_enable, reserve_reg,
        input  read_data_0, read_data_1, read_valid, stall, scoreboard_error
    );

    // Register-file side
    modport slave (
        input  write_address, write_data, write_enable,
        input  read_enable, read_reg_0, read_reg_1, read_use_0, read_use_1,
        input  reserve_enable, reserve_reg,
        output read_data_0, read_data_1, read_valid, stall, scoreboard_error
    );
endinterface

// File: rtl/pipelined_register_file.sv
// Architectural register file with per-register outstanding-write
// scoreboard. Two registered read ports with write-back bypass; stall is
// the only combinational output and depends on pending counts and the
// current-cycle request only.
module pipelined_register_file #(
    parameter int NUM_REGS    = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_PENDING = 3
) (
    input logic                      clk,
    input logic                      rst,
    pipelined_register_file_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(NUM_REGS);
    localparam int CNT_WIDTH  = $clog2(MAX_PENDING + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(MAX_PENDING);

    logic [DATA_WIDTH-1:0] regs_r        [NUM_REGS];
    logic [CNT_WIDTH-1:0]  pending_r     [NUM_REGS];
    logic [CNT_WIDTH-1:0]  pending_nxt_s [NUM_REGS];

    logic [DATA_WIDTH-1:0] read_data_0_r;
    logic [DATA_WIDTH-1:0] read_data_1_r;
    logic                  read_valid_r;
    logic                  scoreboard_error_r;

    logic hit_0_s;
    logic hit_1_s;
    logic hit_rsv_s;
    logic busy_0_s;
    logic busy_1_s;
    logic sat_s;
    logic stall_s;
    logic accept_s;
    logic inc_s;
    logic dec_s;
    logic orphan_s;

    // Hazard detection: a register is busy while writes are outstanding,
    // except when the last outstanding write lands this very cycle (bypass).
    always_comb begin
        hit_0_s   = bus.write_enable && (bus.write_address == bus.read_reg_0);
        hit_1_s   = bus.write_enable && (bus.write_address == bus.read_reg_1);
        hit_rsv_s = bus.write_enable && (bus.write_address == bus.reserve_reg);
        busy_0_s  = (pending_r[bus.read_reg_0] != CNT_ZERO) &&
                    !((pending_r[bus.read_reg_0] == CNT_ONE) && hit_0_s);
        busy_1_s  = (pending_r[bus.read_reg_1] != CNT_ZERO) &&
                    !((pending_r[bus.read_reg_1] == CNT_ONE) && hit_1_s);
        sat_s     = bus.reserve_enable && (pending_r[bus.reserve_reg] == CNT_MAX) && !hit_rsv_s;
        stall_s   = bus.read_enable && ((bus.read_use_0 && busy_0_s) ||
                                        (bus.read_use_1 && busy_1_s) || sat_s);
        accept_s  = bus.read_enable && !stall_s;
        inc_s     = accept_s && bus.reserve_enable;
        dec_s     = bus.write_enable && (pending_r[bus.write_address] != CNT_ZERO);
        orphan_s  = bus.write_enable && (pending_r[bus.write_address] == CNT_ZERO);
    end

    // Next pending count per register; a reserve and a retire on the same
    // register cancel out.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if ((inc_s && (bus.reserve_reg == ADDR_WIDTH'(i))) &&
                !(dec_s && (bus.write_address == ADDR_WIDTH'(i)))) begin
                pending_nxt_s[i] = pending_r[i] + CNT_ONE;
            end else if ((dec_s && (bus.write_address == ADDR_WIDTH'(i))) &&
                         !(inc_s && (bus.reserve_reg == ADDR_WIDTH'(i)))) begin
                pending_nxt_s[i] = pending_r[i] - CNT_ONE;
            end else begin
                pending_nxt_s[i] = pending_r[i];
            end
        end
    end

    // Storage, scoreboard, operand capture and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i]    <= '0;
                pending_r[i] <= '0;
            end
            read_data_0_r      <= '0;
            read_data_1_r      <= '0;
            read_valid_r       <= 1'b0;
            scoreboard_error_r <= 1'b0;
        end else begin
            if (bus.write_enable) begin
                regs_r[bus.write_address] <= bus.write_data;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                pending_r[i] <= pending_nxt_s[i];
            end
            if (accept_s) begin
                read_data_0_r <= hit_0_s ? bus.write_data : regs_r[bus.read_reg_0];
                read_data_1_r <= hit_1_s ? bus.write_data : regs_r[bus.read_reg_1];
                read_valid_r  <= 1'b1;
            end else begin
                read_valid_r  <= 1'b0;
            end
            if (orphan_s) begin
                scoreboard_error_r <= 1'b1;
            end
        end
    end

    assign bus.read_data_0      = read_data_0_r;
    assign bus.read_data_1      = read_data_1_r;
    assign bus.read_valid       = read_valid_r;
    assign bus.scoreboard_error = scoreboard_error_r;
    assign bus.stall            = stall_s;
endmodule

// File: tb/tb_pipelined_register_file.sv
// Directed bench for pipelined_register_file: reset state, bypass, storage
// visibility, scoreboard stalls, saturation and orphan-write error.
module tb_pipelined_register_file;
    logic clk = 1'b0;
    logic rst;
    int   n_compared   = 0;
    int   n_mismatched = 0;

    always #5 clk = ~clk;

    pipelined_register_file_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

    pipelined_register_file #(
        .NUM_REGS(32), .DATA_WIDTH(32), .MAX_PENDING(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic apply(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic re, input logic [4:0] r0, input logic u0,
                         input logic [4:0] r1, input logic u1,
                         input logic rs_en, input logic [4:0] rs);
        bus.write_enable   = we;
        bus.write_address  = wa;
        bus.write_data     = wd;
        bus.read_enable    = re;
        bus.read_reg_0     = r0;
        bus.read_use_0     = u0;
        bus.read_reg_1     = r1;
        bus.read_use_1     = u1;
        bus.reserve_enable = rs_en;
        bus.reserve_reg    = rs;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
        step();
        step();
        rst = 1'b0;
        check_value("rst_valid", {31'd0, bus.read_valid}, 32'd0);
        check_value("rst_rd0", bus.read_data_0, 32'd0);
        check_value("rst_rd1", bus.read_data_1, 32'd0);
        check_value("rst_err", {31'd0, bus.scoreboard_error}, 32'd0);
        check_value("rst_stall", {31'd0, bus.stall}, 32'd0);

        // Read r5, r7 of a clean file
        apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0);
        check_value("clean_stall", {31'd0, bus.stall}, 32'd0);
        step();
        check_value("clean_valid", {31'd0, bus.read_valid}, 32'd1);
        check_value("clean_rd0", bus.read_data_0, 32'd0);
        check_value("clean_rd1", bus.read_data_1, 32'd0);

        // Write r3 with same-cycle read of r3: bypass (orphan write sets error)
        apply(1'b1, 5'd3, 32'hDEADBEEF, 1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0);
        check_value("byp_stall", {31'd0, bus.stall}, 32'd0);
        step();
        check_value("byp_rd0", bus.read_data_0, 32'hDEADBEEF);
        check_value("byp_rd1", bus.read_data_1, 32'd0);
        check_value("byp_err", {31'd0, bus.scoreboard_error}, 32'd1);

        // Later read of r3 from storage
        apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0);
        step();
        check_value("store_rd1", bus.read_data_1, 32'hDEADBEEF);
        check_value("store_rd0", bus.read_data_0, 32'd0);

        // Orphan write to r2, no read: outputs hold, error stays set
        apply(1'b1, 5'd2, 32'h0BAD0002, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
        step();
        check_value("noacc_valid", {31'd0, bus.read_valid}, 32'd0);
        check_value("noacc_rd1_hold", bus.read_data_1, 32'hDEADBEEF);
        apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0);
        step();
        check_value("orphan_rd0", bus.read_data_0, 32'h0BAD0002);
        check_value("orphan_err", {31'd0, bus.scoreboard_error}, 32'd1);

        // Reset clears error and storage; write during reset is ignored
        rst = 1'b1;
        apply(1'b1, 5'd3, 32'h11111111, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0);
        step();
        rst = 1'b0;
        apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
        check_value("rst2_err", {31'd0, bus.scoreboard_error}, 32'd0);
        check_value("rst2_valid", {31'd0, bus.read_valid}, 32'd0);
        check_value("rst2_rd0", bus.read_data_0, 32'd0);
        apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0);
        step();
        check_value("rst2_r3", bus.read_data_0, 32'd0);
        check_value("rst2_r2", bus.read_data_1, 32'd0);

        // Reserve r8, then retire it with a legitimate write
        apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8);
        check_value("rsv8_stall", {31'd0, bus.stall}, 32'd0);
        step();
        check_value("rsv8_valid", {31'd0, bus.read_valid}, 32'd1);
        apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
        check_value("r8_busy", {31'd0, bus.stall}, 32'd1);
        apply(1'b1, 5'd8, 32'h0000CAFE, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
        step();
        check_value("r8_wb_err", {31'd0, bus.scoreboard_error}, 32'd0);

        // Reserve r4 while reading r8
        apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b1, 5'd4);
        check_value("rsv4_stall", {31'd0, bus.stall}, 32'd0);
        step();
        check_value("rsv4_rd0", bus.read_data_0, 32'h0000CAFE);

        // Read r4 stalls until its write-back arrives
        apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
        check_value("r4_stall", {31'd0, bus.stall}, 32'd1);
        step();
        check_value("r4_stall_valid", {31'd0, bus.read_valid}, 32'd0);
        check_value("r4_stall_hold", bus.read_data_0, 32'h0000CAFE);
        apply(1'b1, 5'd4, 32'h00000012, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
        check_value("r4_wb_stall", {31'd0, bus.stall}, 32'd0);
        step();
        check_value("r4_wb_rd0", bus.read_data_0, 32'h00000012);
        check_value("r4_wb_valid", {31'd0, bus.read_valid}, 32'd1);
        check_value("r4_wb_err", {31'd0, bus.scoreboard_error}, 32'd0);
        apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 1'b0, 5'd0);
        check_value("r4_drained", {31'd0, bus.stall}, 32'd0);
        step();
        check_value("r4_store_rd1", bus.read_data_1, 32'h00000012);

        // Saturate r9
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9);
            check_value("r9_rsv_stall", {31'd0, bus.stall}, 32'd0);
            step();
        end
        apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9);
        check_value("r9_sat", {31'd0, bus.stall}, 32'd1);
        apply(1'b1, 5'd9, 32'h00000091, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9);
        check_value("r9_sat_wb", {31'd0, bus.stall}, 32'd0);
        step();
        apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9);
        check_value("r9_still_3", {31'd0, bus.stall}, 32'd1);

        // Drain r9: busy at counts 3 and 2 even with a write, free at 1
        apply(1'b1, 5'd9, 32'h00000092, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
        check_value("r9_p3_stall", {31'd0, bus.stall}, 32'd1);
        step();
        check_value("r9_p3_valid", {31'd0, bus.read_valid}, 32'd0);
        apply(1'b1, 5'd9, 32'h00000093, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
        check_value("r9_p2_stall", {31'd0, bus.stall}, 32'd1);
        step();
        apply(1'b1, 5'd9, 32'h00000094, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
        check_value("r9_p1_stall", {31'd0, bus.stall}, 32'd0);
        step();
        check_value("r9_p1_rd0", bus.read_data_0, 32'h00000094);
        check_value("r9_p1_valid", {31'd0, bus.read_valid}, 32'd1);
        apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 5'd0);
        check_value("r9_free", {31'd0, bus.stall}, 32'd0);
        step();
        check_value("r9_store_rd0", bus.read_data_0, 32'h00000094);
        check_value("r9_store_rd1", bus.read_data_1, 32'h00000094);
        check_value("r9_err", {31'd0, bus.scoreboard_error}, 32'd0);

        // Busy source on an unused port does not stall
        apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd6);
        step();
        apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd6, 1'b0, 1'b0, 5'd0);
        check_value("unused_stall", {31'd0, bus.stall}, 32'd0);
        step();
        check_value("unused_valid", {31'd0, bus.read_valid}, 32'd1);
        check_value("unused_rd0", bus.read_data_0, 32'h00000012);
        apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0, 5'd0);
        check_value("used_stall", {31'd0, bus.stall}, 32'd1);
        apply(1'b1, 5'd6, 32'h00000066, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
        step();
        check_value("final_err", {31'd0, bus.scoreboard_error}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
